// File: rtl/tetris_pkg.sv
// Board geometry, coordinate widths and line-clear FSM encoding shared by
// gamelogic, the VGA painter and line_clear_ctrl.
package tetris_pkg;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int X_W  = 4;
  localparam int Y_W  = 5;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_SCAN_ENC    = 3'd1;
  localparam logic [2:0] ST_FLASH_ENC   = 3'd2;
  localparam logic [2:0] ST_SHIFT_ENC   = 3'd3;
  localparam logic [2:0] ST_TOPFILL_ENC = 3'd4;
  localparam logic [2:0] ST_DONE_ENC    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_SCAN    = ST_SCAN_ENC,
    ST_FLASH   = ST_FLASH_ENC,
    ST_SHIFT   = ST_SHIFT_ENC,
    ST_TOPFILL = ST_TOPFILL_ENC,
    ST_DONE    = ST_DONE_ENC
  } lc_state_e;

endpackage

// File: rtl/line_clear_ctrl_row_scanner.sv
// row_scanner: walks columns 0..COLS-1 of one row while run_i is high, sums
// the occupancy returned one cycle later, and in the 11th (drain) cycle
// reports full/empty with a valid pulse. Wraps automatically so the parent
// can scan consecutive rows back to back.
import tetris_pkg::*;

module row_scanner (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           run_i,
  input  logic           rdata_i,
  output logic [X_W-1:0] col_o,
  output logic           rd_en_o,
  output logic           valid_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam logic [X_W-1:0] X_DRAIN = X_W'(COLS);

  logic [X_W-1:0] col_q, col_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     sum;

  // Column sequencing and late occupancy accumulation.
  always_comb begin
    sum     = cnt_q + {3'b000, rdata_i};
    col_o   = col_q;
    rd_en_o = run_i && (col_q < X_DRAIN);
    valid_o = run_i && (col_q == X_DRAIN);
    full_o  = valid_o && (sum == 4'(COLS));
    empty_o = valid_o && (sum == 4'd0);
    col_d   = '0;
    cnt_d   = '0;
    if (run_i && (col_q != X_DRAIN)) begin
      col_d = col_q + 4'd1;
      cnt_d = (col_q != '0) ? sum : cnt_q;
    end
  end

  // Counter registers; cleared whenever the parent is not scanning.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      col_q <= '0;
      cnt_q <= '0;
    end else begin
      col_q <= col_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: after a piece locks, scans the board bottom-up for full
// rows, collapses each one, and reports rows cleared plus a saturating total.
// Optional build macro LINE_CLEAR_FLASH_EN adds a visible dwell per cleared row.
//
// state   | meaning
// IDLE    | waiting for start
// SCAN    | reading row r, 10 reads + 1 drain cycle
// FLASH   | dwell on full row r (LINE_CLEAR_FLASH_EN only)
// SHIFT   | copy row y-1 into row y, for y = r down to 1
// TOPFILL | write zeros into row 0
// DONE    | one-cycle completion pulse
import tetris_pkg::*;

module line_clear_ctrl #(
  parameter int unsigned FLASH_CYCLES = 32'd12500000
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [4:0]     lines_cleared,
  output logic [7:0]     total_lines,
  output logic [X_W-1:0] mem_rx,
  output logic [Y_W-1:0] mem_ry,
  input  logic           mem_rdata,
  output logic           mem_we,
  output logic [X_W-1:0] mem_wx,
  output logic [Y_W-1:0] mem_wy,
  output logic           mem_wdata,
  output logic [Y_W-1:0] flash_row,
  output logic           flash_active
);

  localparam logic [X_W-1:0] X_LAST  = X_W'(COLS - 1);
  localparam logic [X_W-1:0] X_DRAIN = X_W'(COLS);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(ROWS - 1);

  lc_state_e      state_q, state_d;
  logic [Y_W-1:0] r_q, r_d, y_q, y_d;
  logic [X_W-1:0] k_q, k_d;
  logic [4:0]     lines_q, lines_d;
  logic [7:0]     total_q, total_d;

  logic [X_W-1:0] scan_col;
  logic           scan_rd, scan_valid, scan_full, scan_empty;

`ifdef LINE_CLEAR_FLASH_EN
  localparam int FL_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  logic [FL_W-1:0] fl_q, fl_d;
`endif

  row_scanner u_scan (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .run_i    (state_q == ST_SCAN),
    .rdata_i  (mem_rdata),
    .col_o    (scan_col),
    .rd_en_o  (scan_rd),
    .valid_o  (scan_valid),
    .full_o   (scan_full),
    .empty_o  (scan_empty)
  );

  // Next-state, counters and memory port drive.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    y_d       = y_q;
    k_d       = k_q;
    lines_d   = lines_q;
    total_d   = total_q;
`ifdef LINE_CLEAR_FLASH_EN
    fl_d      = fl_q;
`endif
    busy      = 1'b0;
    done      = 1'b0;
    mem_rx    = '0;
    mem_ry    = '0;
    mem_we    = 1'b0;
    mem_wx    = '0;
    mem_wy    = '0;
    mem_wdata = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d     = Y_LAST;
          lines_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (scan_rd) begin
          mem_rx = scan_col;
          mem_ry = r_q;
        end
        if (scan_valid) begin
          if (scan_full) begin
            lines_d = lines_q + 5'd1;
            total_d = (total_q == 8'hFF) ? total_q : total_q + 8'd1;
            y_d     = r_q;
            k_d     = '0;
`ifdef LINE_CLEAR_FLASH_EN
            fl_d    = FL_W'(FLASH_CYCLES - 1);
            state_d = ST_FLASH;
`else
            state_d = (r_q != '0) ? ST_SHIFT : ST_TOPFILL;
`endif
          end else if (scan_empty || (r_q == '0)) begin
            state_d = ST_DONE;
          end else begin
            r_d = r_q - 5'd1;
          end
        end
      end
`ifdef LINE_CLEAR_FLASH_EN
      ST_FLASH: begin
        busy = 1'b1;
        if (fl_q == '0) begin
          state_d = (r_q != '0) ? ST_SHIFT : ST_TOPFILL;
        end else begin
          fl_d = fl_q - 1'b1;
        end
      end
`endif
      ST_SHIFT: begin
        busy = 1'b1;
        if (k_q != X_DRAIN) begin
          mem_rx = k_q;
          mem_ry = y_q - 5'd1;
        end
        // Data read in the previous cycle lands one row lower.
        if (k_q != '0) begin
          mem_we    = 1'b1;
          mem_wx    = k_q - 4'd1;
          mem_wy    = y_q;
          mem_wdata = mem_rdata;
        end
        if (k_q == X_DRAIN) begin
          k_d = '0;
          if (y_q == 5'd1) begin
            state_d = ST_TOPFILL;
          end else begin
            y_d = y_q - 5'd1;
          end
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_TOPFILL: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        mem_wx = k_q;
        if (k_q == X_LAST) begin
          k_d     = '0;
          state_d = (r_q == '0) ? ST_DONE : ST_SCAN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      lines_q <= '0;
      total_q <= '0;
`ifdef LINE_CLEAR_FLASH_EN
      fl_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      y_q     <= y_d;
      k_q     <= k_d;
      lines_q <= lines_d;
      total_q <= total_d;
`ifdef LINE_CLEAR_FLASH_EN
      fl_q    <= fl_d;
`endif
    end
  end

  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

`ifdef LINE_CLEAR_FLASH_EN
  assign flash_active = (state_q == ST_FLASH);
  assign flash_row    = flash_active ? r_q : '0;
`else
  assign flash_active = 1'b0;
  assign flash_row    = '0;
`endif

endmodule
